// File: rtl/captura_pkg.sv
`default_nettype none
// ============================================================================
// Module      : captura_pkg
// Description : Shared constants and helpers for the OV7670 capture path.
// Revision    : 1.0 - initial release
// ============================================================================

package captura_pkg;

    localparam int FMT_RGB332 = 0;
    localparam int FMT_RGB444 = 1;
    localparam int FMT_RGB565 = 2;

    localparam logic [0:0] ST_SYNC   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    function automatic int dw_of_fmt(input int fmt);
        case (fmt)
            FMT_RGB444: return 12;
            FMT_RGB565: return 16;
            default:    return 8;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/captura_pixel_pack.sv
`default_nettype none
// ============================================================================
// Module      : captura_pixel_pack
// Description : Combinational RGB565 to storage-format converter.
// Revision    : 1.0 - initial release
// ============================================================================

module captura_pixel_pack
    import captura_pkg::*;
#(
    parameter int FMT = FMT_RGB332,
    parameter int DW  = dw_of_fmt(FMT)
) (
    input  logic [15:0]   px_i,
    output logic [DW-1:0] word_o
);

    generate
        if (FMT == FMT_RGB565) begin : g_rgb565
            assign word_o = px_i;
        end else if (FMT == FMT_RGB444) begin : g_rgb444
            logic unused_bits;
            assign unused_bits = ^{px_i[11], px_i[6:5], px_i[0]};
            assign word_o      = {px_i[15:12], px_i[10:7], px_i[4:1]};
        end else begin : g_rgb332
            logic unused_bits;
            assign unused_bits = ^{px_i[12:11], px_i[7:5], px_i[2:0]};
            assign word_o      = {px_i[15:13], px_i[10:8], px_i[4:3]};
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/captura_datos_param.sv
`default_nettype none
// ============================================================================
// Module      : captura_datos_param
// Description : OV7670 byte-stream capture with decimation, writing the frame RAM.
// Revision    : 1.0 - initial release
// ============================================================================

module captura_datos_param
    import captura_pkg::*;
#(
    parameter int FMT     = FMT_RGB332,
    parameter int IN_W    = 320,
    parameter int IN_H    = 240,
    parameter int DECIM_H = 1,
    parameter int DECIM_V = 1,
    parameter int DEPTH   = (IN_W / DECIM_H) * (IN_H / DECIM_V),
    parameter int AW      = $clog2(DEPTH),
    parameter int DW      = dw_of_fmt(FMT)
) (
    input  logic          PCLK,
    input  logic          RESETN,
    input  logic          HREF,
    input  logic          VSYNC,
    input  logic [7:0]    D,
    output logic [DW-1:0] DP_RAM_data_in,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic          DP_RAM_regW,
    output logic          frame_done,
    output logic          overflow,
    output logic          line_err
);

    localparam int COL_W = $clog2(IN_W + 1);
    localparam int ROW_W = $clog2(IN_H + 1);
    localparam int PTR_W = AW + 1;

    localparam logic [COL_W-1:0] COL_MAX   = COL_W'(IN_W);
    localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(IN_H);
    localparam logic [COL_W-1:0] COL_MASK  = COL_W'(DECIM_H - 1);
    localparam logic [ROW_W-1:0] ROW_MASK  = ROW_W'(DECIM_V - 1);
    localparam logic [PTR_W-1:0] PTR_LIMIT = PTR_W'(DEPTH);

    logic [0:0]       state_q, state_d;
    logic             href_q, vsync_q;
    logic             phase_q, phase_d;
    logic [7:0]       hi_q, hi_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [DW-1:0]    data_q, data_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             regw_q, regw_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             lerr_q, lerr_d;

    logic [DW-1:0]    packed_px;
    logic             vsync_rise, vsync_fall, href_fall, byte_ok, keep;

    captura_pixel_pack #(
        .FMT (FMT),
        .DW  (DW)
    ) u_pack (
        .px_i   ({hi_q, D}),
        .word_o (packed_px)
    );

    assign vsync_rise = VSYNC & ~vsync_q;
    assign vsync_fall = ~VSYNC & vsync_q;
    assign href_fall  = ~HREF & href_q;
    assign byte_ok    = (state_q == ST_ACTIVE) && HREF && !VSYNC;
    // Decimation factors are powers of two, so modulo reduces to a mask.
    assign keep       = ((col_q & COL_MASK) == '0) && ((row_q & ROW_MASK) == '0);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hi_d    = hi_q;
        col_d   = col_q;
        row_d   = row_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        addr_d  = addr_q;
        regw_d  = 1'b0;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        lerr_d  = lerr_q;

        if (state_q == ST_SYNC) begin
            if (vsync_fall) begin
                state_d = ST_ACTIVE;
            end
        end else if (vsync_rise) begin
            // Frame end wins over a coincident HREF fall: row must stay at zero.
            state_d = ST_SYNC;
            done_d  = (ptr_q != '0);
            ptr_d   = '0;
            row_d   = '0;
            col_d   = '0;
            phase_d = 1'b0;
        end else if (href_fall) begin
            if (phase_q) begin
                lerr_d = 1'b1;
            end
            phase_d = 1'b0;
            col_d   = '0;
            if (row_q != ROW_MAX) begin
                row_d = row_q + ROW_W'(1);
            end
        end else if (byte_ok) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                hi_d = D;
            end else begin
                if (col_q != COL_MAX) begin
                    col_d = col_q + COL_W'(1);
                end
                if (keep) begin
                    if (ptr_q < PTR_LIMIT) begin
                        data_d = packed_px;
                        addr_d = ptr_q[AW-1:0];
                        regw_d = 1'b1;
                        ptr_d  = ptr_q + PTR_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!RESETN) begin
            state_q <= ST_SYNC;
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
            phase_q <= 1'b0;
            hi_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            ptr_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            regw_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            href_q  <= HREF;
            vsync_q <= VSYNC;
            phase_q <= phase_d;
            hi_q    <= hi_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            regw_q  <= regw_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            lerr_q  <= lerr_d;
        end
    end

    assign DP_RAM_data_in = data_q;
    assign DP_RAM_addr_in = addr_q;
    assign DP_RAM_regW    = regw_q;
    assign frame_done     = done_q;
    assign overflow       = ovf_q;
    assign line_err       = lerr_q;

endmodule

`default_nettype wire

// File: tb/tb_captura_datos_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_captura_datos_param
// Description : Directed self-checking bench for captura_datos_param.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_captura_datos_param;

    logic       PCLK   = 1'b0;
    logic       RESETN = 1'b0;
    logic       HREF   = 1'b0;
    logic       VSYNC  = 1'b0;
    logic [7:0] D      = 8'h00;

    always #5 PCLK = ~PCLK;

    // A: defaults (RGB332, 320x240). B: RGB565 8x4 decimated by 2. C: RGB565 DEPTH=4.
    logic [7:0]  a_data;  logic [16:0] a_addr;
    logic        a_regw, a_fd, a_ovf, a_lerr;
    logic [15:0] b_data;  logic [2:0]  b_addr;
    logic        b_regw, b_fd, b_ovf, b_lerr;
    logic [15:0] c_data;  logic [1:0]  c_addr;
    logic        c_regw, c_fd, c_ovf, c_lerr;

    captura_datos_param u_a (
        .PCLK(PCLK), .RESETN(RESETN), .HREF(HREF), .VSYNC(VSYNC), .D(D),
        .DP_RAM_data_in(a_data), .DP_RAM_addr_in(a_addr), .DP_RAM_regW(a_regw),
        .frame_done(a_fd), .overflow(a_ovf), .line_err(a_lerr)
    );

    captura_datos_param #(
        .FMT(2), .IN_W(8), .IN_H(4), .DECIM_H(2), .DECIM_V(2)
    ) u_b (
        .PCLK(PCLK), .RESETN(RESETN), .HREF(HREF), .VSYNC(VSYNC), .D(D),
        .DP_RAM_data_in(b_data), .DP_RAM_addr_in(b_addr), .DP_RAM_regW(b_regw),
        .frame_done(b_fd), .overflow(b_ovf), .line_err(b_lerr)
    );

    captura_datos_param #(
        .FMT(2), .IN_W(8), .IN_H(4), .DEPTH(4)
    ) u_c (
        .PCLK(PCLK), .RESETN(RESETN), .HREF(HREF), .VSYNC(VSYNC), .D(D),
        .DP_RAM_data_in(c_data), .DP_RAM_addr_in(c_addr), .DP_RAM_regW(c_regw),
        .frame_done(c_fd), .overflow(c_ovf), .line_err(c_lerr)
    );

    logic [63:0] qa[$];
    logic [63:0] qb[$];
    logic [63:0] qc[$];
    int fda = 0;
    int fdb = 0;
    int checks = 0;
    int errors = 0;

    // Write log: {address, data} per strobe cycle.
    always @(negedge PCLK) begin
        if (a_regw) qa.push_back({32'(a_addr), 32'(a_data)});
        if (b_regw) qb.push_back({32'(b_addr), 32'(b_data)});
        if (c_regw) qc.push_back({32'(c_addr), 32'(c_data)});
        if (a_fd) fda++;
        if (b_fd) fdb++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] entry(input logic [63:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return '1;
    endfunction

    task automatic cyc(input logic h, input logic v, input logic [7:0] d);
        @(negedge PCLK);
        HREF  = h;
        VSYNC = v;
        D     = d;
    endtask

    task automatic send_pixel(input logic [15:0] px);
        cyc(1'b1, 1'b0, px[15:8]);
        cyc(1'b1, 1'b0, px[7:0]);
    endtask

    task automatic end_line();
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic vsync_pulse();
        repeat (3) cyc(1'b0, 1'b1, 8'h00);
        repeat (2) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        RESETN = 1'b0;
        HREF   = 1'b0;
        VSYNC  = 1'b0;
        D      = 8'h00;
        repeat (2) @(negedge PCLK);
        RESETN = 1'b1;
        qa.delete();
        qb.delete();
        qc.delete();
        fda = 0;
        fdb = 0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_data", a_data, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_regw", a_regw, 0);
        chk("rst_fd",   a_fd,   0);
        chk("rst_ovf",  a_ovf,  0);
        chk("rst_lerr", a_lerr, 0);

        // One line of four 0xF81F pixels into RGB332
        vsync_pulse();
        for (int i = 0; i < 4; i++) send_pixel(16'hF81F);
        end_line();
        chk("t1_count", qa.size(), 4);
        for (int i = 0; i < 4; i++) chk("t1_wr", entry(qa, i), {32'(i), 32'h0000_00E3});
        chk("t1_lerr", a_lerr, 0);

        // Full 8x4 frame, pixel = col, decimated 2x2
        do_reset();
        vsync_pulse();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) send_pixel(16'(c));
            end_line();
        end
        repeat (3) cyc(1'b0, 1'b1, 8'h00);
        chk("t2_count", qb.size(), 8);
        for (int i = 0; i < 8; i++) chk("t2_wr", entry(qb, i), {32'(i), 32'((i % 4) * 2)});
        chk("t2_fd", fdb, 1);

        // Odd-length line followed by an aligned line
        do_reset();
        vsync_pulse();
        cyc(1'b1, 1'b0, 8'hF8);
        cyc(1'b1, 1'b0, 8'h1F);
        cyc(1'b1, 1'b0, 8'hF8);
        end_line();
        send_pixel(16'h07E0);
        end_line();
        chk("t3_lerr",  a_lerr, 1);
        chk("t3_count", qa.size(), 2);
        chk("t3_wr0", entry(qa, 0), {32'd0, 32'h0000_00E3});
        chk("t3_wr1", entry(qa, 1), {32'd1, 32'h0000_001C});

        // Six pixels into a 4-word RAM
        do_reset();
        vsync_pulse();
        for (int i = 0; i < 6; i++) send_pixel(16'h0100 + 16'(i));
        end_line();
        chk("t4_count", qc.size(), 4);
        for (int i = 0; i < 4; i++) chk("t4_wr", entry(qc, i), {32'(i), 32'(16'h0100 + 16'(i))});
        chk("t4_ovf", c_ovf, 1);

        // One-cycle reset in the middle of a line
        vsync_pulse();
        send_pixel(16'hF81F);
        cyc(1'b1, 1'b0, 8'hF8);
        @(negedge PCLK);
        RESETN = 1'b0;
        HREF   = 1'b1;
        D      = 8'h1F;
        qa.delete();
        @(negedge PCLK);
        chk("t5_data", a_data, 0);
        chk("t5_addr", a_addr, 0);
        chk("t5_regw", a_regw, 0);
        chk("t5_fd",   a_fd,   0);
        chk("t5_lerr", a_lerr, 0);
        chk("t5_covf", c_ovf,  0);
        RESETN = 1'b1;
        HREF   = 1'b1;
        D      = 8'hF8;
        cyc(1'b1, 1'b0, 8'h1F);
        send_pixel(16'hF81F);
        end_line();
        chk("t5_nowr", qa.size(), 0);
        vsync_pulse();
        send_pixel(16'h07E0);
        end_line();
        chk("t5_count", qa.size(), 1);
        chk("t5_wr0", entry(qa, 0), {32'd0, 32'h0000_001C});

        // HREF fall coincident with VSYNC rise
        do_reset();
        vsync_pulse();
        send_pixel(16'h0011);
        send_pixel(16'h0022);
        repeat (3) cyc(1'b0, 1'b1, 8'h00);
        chk("t6_fd", fdb, 1);
        chk("t6_first", entry(qb, 0), {32'd0, 32'h0000_0011});
        qb.delete();
        repeat (2) cyc(1'b0, 1'b0, 8'h00);
        send_pixel(16'h0055);
        send_pixel(16'h0066);
        end_line();
        chk("t6_count", qb.size(), 1);
        chk("t6_wr0", entry(qb, 0), {32'd0, 32'h0000_0055});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
